// File: rtl/decoder_2x4_seq_pkg.sv
// Shared definitions for the sequential 2-to-4 decoder and its companion encoder bench.
// Holds the FSM state encoding and the output-width formula so both sides agree.
// Pure declarations; no logic, no latency, no backpressure.
package decoder_2x4_seq_pkg;

  // IDLE drives Y to zero; HOLD keeps a one-hot pattern on Y.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One output line per possible input code.
  function automatic int out_width(input int in_w);
    return 1 << in_w;
  endfunction

  // Hold counter counts down from HOLD_CYCLES-1 to 0 and never wraps.
  function automatic int cnt_width(input int hold_cycles);
    return $clog2(hold_cycles) + 1;
  endfunction

endpackage

// File: rtl/decoder_2x4_seq_sync_fifo.sv
// Generic single-clock FIFO holding input codes until the decoder FSM consumes them.
// Latency: an entry written at edge k is visible on dout and poppable from edge k+1 (no bypass).
// Backpressure: full is derived from the registered count; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Status flags come straight from the registered count so in_ready has no combinational path from pop.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/decoder_2x4_seq.sv
// Sequential one-hot decoder: buffers binary codes and replays each as a one-hot Y held HOLD_CYCLES clocks.
// Latency: a code accepted at edge k while idle with en=1 is popped at edge k+1 and shows on Y right after it.
// Backpressure: in_ready falls when the input FIFO is full; en=0 stalls new pops but never cuts a hold short.
module decoder_2x4_seq
  import decoder_2x4_seq_pkg::*;
#(
  parameter  int IN_W        = 2,
  parameter  int HOLD_CYCLES = 4,
  parameter  int FIFO_DEPTH  = 4,
  localparam int OUT_W       = out_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             en,
  output logic [OUT_W-1:0] Y,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [OUT_W-1:0]  y_nxt;
  logic [OUT_W-1:0]  y_load;
  logic [IN_W-1:0]   fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              can_start;

  sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_code),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state == HOLD);
  assign can_start = !fifo_empty && en;
  assign y_load    = OUT_W'(1) << fifo_dout;

  // Next-state, hold countdown, output pattern and the done pulse; en only matters at pop decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    y_nxt     = Y;
    pop       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (can_start) begin
          pop       = 1'b1;
          y_nxt     = y_load;
          cnt_nxt   = CNT_LOAD;
          state_nxt = HOLD;
        end else begin
          y_nxt = '0;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          done = 1'b1;
          if (can_start) begin
            // Back-to-back: load the next code on the same edge the current hold ends.
            pop       = 1'b1;
            y_nxt     = y_load;
            cnt_nxt   = CNT_LOAD;
            state_nxt = HOLD;
          end else begin
            y_nxt     = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        y_nxt     = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and registered one-hot output; reset clears everything at once, mid-hold included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      Y     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Y     <= y_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_2x4_seq.sv
// Scoreboard bench: accepted codes are queued as expectations, a negedge monitor checks Y against them.
// Directed scenarios cover spacing, bursts, full FIFO, en gating, async reset and HOLD_CYCLES=1.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_decoder_2x4_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       en;
  logic [3:0] Y;
  logic       busy;
  logic       done;

  logic       in_valid1;
  logic       in_ready1;
  logic [1:0] in_code1;
  logic       en1;
  logic [3:0] Y1;
  logic       busy1;
  logic       done1;

  int vectors = 0;
  int miscompares = 0;
  int hold_cnt = 0;
  logic [1:0] exp_q[$];

  decoder_2x4_seq #(.IN_W(2), .HOLD_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .en(en), .Y(Y), .busy(busy), .done(done)
  );

  decoder_2x4_seq #(.IN_W(2), .HOLD_CYCLES(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_code(in_code1), .en(en1), .Y(Y1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every busy cycle must show the one-hot of the oldest accepted code for exactly 4 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_cnt = 0;
    end else if (busy) begin
      hold_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {28'd0, Y}, 32'd0);
      end else begin
        chk("y_code", {28'd0, Y}, 32'd1 << exp_q[0]);
        if (done) begin
          chk("hold_len", hold_cnt, 32'd4);
          hold_cnt = 0;
          void'(exp_q.pop_front());
        end
      end
    end else begin
      chk("idle_y", {28'd0, Y}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
    end
  end

  // Offer one code from a falling edge; returns on the falling edge after the transfer.
  task automatic send(input logic [1:0] c);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_code  = c;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(c);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain", {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [1:0] codes1 [4];
    logic [3:0] y1_tab [4];
    logic [1:0] burst  [4];
    logic [3:0] y2_tab [4];
    logic [1:0] full5  [4];

    codes1 = '{2'd0, 2'd1, 2'd2, 2'd3};
    y1_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    burst  = '{2'd3, 2'd0, 2'd2, 2'd1};
    y2_tab = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
    full5  = '{2'd1, 2'd3, 2'd0, 2'd2};

    rst_n = 1'b0; in_valid = 1'b0; in_code = 2'd0; en = 1'b1;
    in_valid1 = 1'b0; in_code1 = 2'd0; en1 = 1'b0;
    #1;
    chk("reset_y", {28'd0, Y}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1) Spaced codes: one cycle of latency, then 4 cycles of one-hot, then zero.
    for (int i = 0; i < 4; i++) begin
      send(codes1[i]);
      chk("t1_latency_zero", {28'd0, Y}, 32'd0);
      @(negedge clk);
      chk("t1_first_cycle", {28'd0, Y}, {28'd0, y1_tab[i]});
      repeat (9) @(negedge clk);
    end
    wait_drain();

    // 2) Burst of four into a paused decoder, then a 16-cycle contiguous replay.
    en = 1'b0;
    for (int i = 0; i < 4; i++) send(burst[i]);
    chk("t2_ready_full", {31'd0, in_ready}, 32'd0);
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t2_busy", {31'd0, busy}, 32'd1);
      chk("t2_y", {28'd0, Y}, {28'd0, y2_tab[i/4]});
      chk("t2_done", {31'd0, done}, {31'd0, (i % 4 == 3)});
    end
    @(negedge clk);
    chk("t2_after", {28'd0, Y}, 32'd0);
    wait_drain();

    // 3) Fifth code is held off by a full FIFO until en drains it.
    en = 1'b0;
    for (int i = 0; i < 4; i++) send(full5[i]);
    fork
      send(2'd3);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t3_ready_low", {31'd0, in_ready}, 32'd0);
          chk("t3_y_zero", {28'd0, Y}, 32'd0);
        end
        en = 1'b1;
      end
    join
    wait_drain();

    // 4) en dropped mid-hold: the hold finishes, the queued code waits for en.
    en = 1'b1;
    send(2'd2);
    send(2'd1);
    chk("t4_hold1", {28'd0, Y}, 32'h4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_rest", {28'd0, Y}, 32'h4);
    end
    repeat (5) begin
      @(negedge clk);
      chk("t4_paused_y", {28'd0, Y}, 32'd0);
      chk("t4_paused_busy", {31'd0, busy}, 32'd0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("t4_resume", {28'd0, Y}, 32'h2);
    wait_drain();

    // 5) Asynchronous reset mid-hold with two codes still queued.
    send(2'd0);
    send(2'd1);
    send(2'd2);
    chk("t5_holding", {28'd0, Y}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_y", {28'd0, Y}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("t5_no_stale", {27'd0, busy, Y}, 32'd0);
    end

    // 6) HOLD_CYCLES=1: four single-cycle pulses with done high throughout.
    for (int i = 0; i < 4; i++) begin
      in_valid1 = 1'b1;
      in_code1  = codes1[i];
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    chk("t6_full", {31'd0, in_ready1}, 32'd0);
    en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_y", {28'd0, Y1}, {28'd0, y1_tab[i]});
      chk("t6_done", {31'd0, done1}, 32'd1);
      chk("t6_busy", {31'd0, busy1}, 32'd1);
    end
    @(negedge clk);
    chk("t6_end_y", {28'd0, Y1}, 32'd0);
    chk("t6_end_done", {31'd0, done1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
